// File: rtl/sfp_link_ctrl_if.sv
// sfp_link_ctrl_if: write-command bus between the link controller and the I2C master
interface sfp_link_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       cmd_done;
  logic       cmd_err;
  modport master(output cmd_valid, cmd_dev, cmd_reg, cmd_data, input cmd_ready, cmd_done, cmd_err);
  modport slave(input cmd_valid, cmd_dev, cmd_reg, cmd_data, output cmd_ready, cmd_done, cmd_err);
endinterface

// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: configures the clock synthesizer over I2C, waits for lock, then supervises the SFP link
module sfp_link_ctrl #(
  parameter logic [15:0] STARTUP_WAIT = 16'd10000,
  parameter logic [15:0] LOCK_TIME    = 16'd1000,
  parameter logic [15:0] RETRY_WAIT   = 16'd5000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3,
  parameter logic [6:0]  DEV_ADDR     = 7'h68
) (
  input  logic                  clk100,
  input  logic                  sys_rst_n,
  output logic [5:0]            cfg_addr,
  input  logic [15:0]           cfg_data,
  sfp_link_ctrl_if.master       cmd,
  input  logic                  clk_alarm_b,
  input  logic                  tx_fault,
  input  logic                  rx_los,
  input  logic                  reconf,
  output logic                  tx_disable,
  output logic                  link_up,
  output logic                  cfg_err,
  output logic [7:0]            fault_cnt
);
  typedef enum logic [2:0] {STARTUP, FETCH, ISSUE, WAIT, LOCK, RUN, FAULT_HOLD, ERROR} state_t;
  state_t      state, next_state;
  logic [1:0]  alarm_q, fault_q, los_q;
  logic        alarm_s, fault_s, los_s;
  logic [15:0] cnt;
  logic [1:0]  retry;
  logic        done_ok, done_bad, load, restart;
  assign alarm_s    = alarm_q[1];
  assign fault_s    = fault_q[1];
  assign los_s      = los_q[1];
  assign tx_disable = state != RUN;
  assign done_ok    = state == WAIT && cmd.cmd_done && !cmd.cmd_err;
  assign done_bad   = state == WAIT && cmd.cmd_done && cmd.cmd_err;
  assign load       = state == FETCH && next_state == ISSUE;
  assign restart    = next_state == FETCH && (state == STARTUP || state == RUN || state == ERROR);
  // two-flop synchronizers for the asynchronous status lines
  always_ff @(posedge clk100 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      alarm_q <= 2'b00;
      fault_q <= 2'b00;
      los_q   <= 2'b00;
    end else begin
      alarm_q <= {alarm_q[0], clk_alarm_b};
      fault_q <= {fault_q[0], tx_fault};
      los_q   <= {los_q[0], rx_los};
    end
  // state register
  always_ff @(posedge clk100 or negedge sys_rst_n)
    if (!sys_rst_n) state <= STARTUP;
    else state <= next_state;
  // next-state decode; in RUN a TX fault outranks a clock alarm, which outranks reconf
  always_comb begin
    next_state = state;
    case (state)
      STARTUP:    if (cnt == STARTUP_WAIT - 16'd1) next_state = FETCH;
      FETCH:      if (cnt != 16'd0) next_state = cfg_data == 16'hFFFF ? LOCK : ISSUE;
      ISSUE:      if (cmd.cmd_valid && cmd.cmd_ready) next_state = WAIT;
      WAIT:       if (done_ok) next_state = cfg_addr == 6'd63 ? LOCK : FETCH;
                  else if (done_bad) next_state = retry == MAX_RETRY - 2'd1 ? ERROR : ISSUE;
      LOCK:       if (alarm_s && cnt == LOCK_TIME - 16'd1) next_state = RUN;
      RUN:        next_state = fault_s ? FAULT_HOLD : !alarm_s ? LOCK : reconf ? FETCH : RUN;
      FAULT_HOLD: if (cnt == RETRY_WAIT - 16'd1) next_state = LOCK;
      ERROR:      if (reconf) next_state = FETCH;
      default:    next_state = STARTUP;
    endcase
  end
  // shared cycle counter (cleared on every state change and by a clock alarm in LOCK), table walk, command fields and status
  always_ff @(posedge clk100 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt           <= 16'd0;
      retry         <= 2'd0;
      cfg_addr      <= 6'd0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_dev   <= 7'd0;
      cmd.cmd_reg   <= 8'd0;
      cmd.cmd_data  <= 8'd0;
      link_up       <= 1'b0;
      cfg_err       <= 1'b0;
      fault_cnt     <= 8'd0;
    end else begin
      cnt           <= (next_state != state || (state == LOCK && !alarm_s)) ? 16'd0 : cnt + 16'd1;
      cmd.cmd_valid <= next_state == ISSUE;
      link_up       <= next_state == RUN && !los_s && !fault_s;
      if (load) begin
        cmd.cmd_dev  <= DEV_ADDR;
        cmd.cmd_reg  <= cfg_data[15:8];
        cmd.cmd_data <= cfg_data[7:0];
      end
      if (done_ok) begin
        cfg_addr <= cfg_addr + 6'd1;
        retry    <= 2'd0;
      end
      if (done_bad) retry <= retry + 2'd1;
      if (next_state == ERROR && state != ERROR) cfg_err <= 1'b1;
      if (restart) begin
        cfg_addr <= 6'd0;
        retry    <= 2'd0;
        cfg_err  <= 1'b0;
      end
      if (state == RUN && next_state == FAULT_HOLD && fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end
endmodule

// File: tb/tb_sfp_link_ctrl.sv
// tb_sfp_link_ctrl: directed self-checking bench with a table ROM, an I2C responder and a per-cycle link model
module tb_sfp_link_ctrl;
  localparam logic [15:0] SW = 16'd16;
  localparam logic [15:0] LT = 16'd40;
  localparam logic [15:0] RW = 16'd24;
  logic        clk100 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_data = 16'h0000;
  logic        clk_alarm_b = 1'b1, tx_fault = 1'b0, rx_los = 1'b0, reconf = 1'b0;
  logic        tx_disable, link_up, cfg_err;
  logic [7:0]  fault_cnt;
  logic [15:0] rom [64];
  logic [22:0] exp_w [512];
  logic [22:0] prev_f = '0;
  logic [2:0]  los_h = '0, flt_h = '0;
  logic        prev_v = 1'b0;
  int          cyc = 0, n_done = 0, err_until = 0, hs_idx = 0, exp_n = 0, done_cyc = 0, done_cd = 0;
  int          checks = 0, passes = 0, model_faults = 0, t = 0, k = 0;
  sfp_link_ctrl_if bus();
  sfp_link_ctrl #(.STARTUP_WAIT(SW), .LOCK_TIME(LT), .RETRY_WAIT(RW), .MAX_RETRY(2'd3), .DEV_ADDR(7'h68)) dut (
    .clk100(clk100), .sys_rst_n(sys_rst_n), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cmd(bus),
    .clk_alarm_b(clk_alarm_b), .tx_fault(tx_fault), .rx_los(rx_los), .reconf(reconf),
    .tx_disable(tx_disable), .link_up(link_up), .cfg_err(cfg_err), .fault_cnt(fault_cnt));
  always #5 clk100 = ~clk100;
  always @(posedge clk100) cfg_data <= rom[cfg_addr];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask
  function automatic logic [22:0] fields();
    return {bus.cmd_dev, bus.cmd_reg, bus.cmd_data};
  endfunction
  // one clock: per-cycle model checks and I2C responder just after the edge, then return on the falling edge
  task automatic tick();
    @(posedge clk100);
    #1;
    cyc++;
    los_h = {los_h[1:0], rx_los};
    flt_h = {flt_h[1:0], tx_fault};
    check("link_model", link_up, !tx_disable && !los_h[2] && !flt_h[2]);
    check("err_forces_txdis", cfg_err && !tx_disable, 1'b0);
    if (sys_rst_n && prev_v && !bus.cmd_ready) check("cmd_hold", {bus.cmd_valid, fields()}, {1'b1, prev_f});
    bus.cmd_done = 1'b0;
    bus.cmd_err = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        bus.cmd_done = 1'b1;
        bus.cmd_err = n_done < err_until;
        n_done++;
        done_cyc = cyc;
      end
    end
    if (sys_rst_n && prev_v && bus.cmd_ready) begin
      if (hs_idx < exp_n) check("write", prev_f, exp_w[hs_idx]);
      else check("extra_write", hs_idx + 1, exp_n);
      hs_idx++;
      done_cd = 3;
    end
    prev_v = bus.cmd_valid;
    prev_f = fields();
    @(negedge clk100);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  function automatic logic sig(input int sel);
    return sel == 0 ? tx_disable : sel == 1 ? bus.cmd_valid : cfg_err;
  endfunction
  task automatic wait_for(input string nm, input int sel, input logic v, input int max, output int n);
    n = 0;
    while (sig(sel) !== v && n < max) begin
      tick();
      n++;
    end
    check(nm, sig(sel), v);
  endtask
  task automatic push(input logic [7:0] r, input logic [7:0] d);
    exp_w[exp_n] = {7'h68, r, d};
    exp_n++;
  endtask
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("rst_valid_drop", bus.cmd_valid, 1'b0);
    prev_v = 1'b0;
    done_cd = 0;
    @(negedge clk100);
    ticks(3);
    check("rst_txdis", tx_disable, 1'b1);
    check("rst_link", link_up, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_fault_cnt", fault_cnt, 8'd0);
    check("rst_addr", cfg_addr, 6'd0);
    check("rst_fields", fields(), 23'd0);
    exp_n = hs_idx;
    sys_rst_n = 1'b1;
  endtask
  initial begin
    bus.cmd_ready = 1'b1;
    bus.cmd_done = 1'b0;
    bus.cmd_err = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h0A55;
    rom[1] = 16'h1BAA;
    @(negedge clk100);
    do_reset();
    push(8'h0A, 8'h55);
    push(8'h1B, 8'hAA);
    wait_for("first_valid", 1, 1'b1, 100, t);
    check("startup_latency", t, SW + 2);
    check("first_fields", fields(), {7'h68, 8'h0A, 8'h55});
    wait_for("reach_run", 0, 1'b0, 500, t);
    check("two_writes", hs_idx, exp_n);
    check("lock_after_done", cyc - done_cyc, LT + 3);
    check("run_link_up", link_up, 1'b1);
    rx_los = 1'b1;
    ticks(6);
    check("los_link_down", link_up, 1'b0);
    check("los_txdis", tx_disable, 1'b0);
    rx_los = 1'b0;
    ticks(6);
    check("los_recover", link_up, 1'b1);
    tx_fault = 1'b1;
    clk_alarm_b = 1'b0;
    k = cyc;
    tick();
    tx_fault = 1'b0;
    clk_alarm_b = 1'b1;
    model_faults++;
    wait_for("fault_txdis", 0, 1'b1, 10, t);
    check("fault_latency", cyc - k, 3);
    check("fault_cnt_1", fault_cnt, 8'd1);
    wait_for("fault_recover", 0, 1'b0, 200, t);
    check("fault_hold_len", cyc - k, 3 + RW + LT);
    clk_alarm_b = 1'b0;
    k = cyc;
    tick();
    clk_alarm_b = 1'b1;
    wait_for("alarm_to_lock", 0, 1'b1, 10, t);
    check("alarm_latency", cyc - k, 3);
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 19; i++) begin
        tick();
        check("no_run_while_toggling", tx_disable, 1'b1);
      end
      clk_alarm_b = 1'b0;
      k = cyc;
      tick();
      clk_alarm_b = 1'b1;
    end
    wait_for("steady_lock", 0, 1'b0, 200, t);
    check("lock_time_after_alarm", cyc - k, LT + 3);
    for (int i = 0; i < 300; i++) begin
      tx_fault = 1'b1;
      tick();
      tx_fault = 1'b0;
      model_faults++;
      wait_for("multi_fault_hold", 0, 1'b1, 10, t);
      wait_for("multi_fault_run", 0, 1'b0, 200, t);
      if (i == 99) check("fault_cnt_101", fault_cnt, model_faults < 255 ? model_faults : 255);
    end
    check("fault_cnt_model", fault_cnt, model_faults < 255 ? model_faults : 255);
    check("fault_cnt_sat", fault_cnt, 8'd255);
    do_reset();
    err_until = n_done + 3;
    push(8'h0A, 8'h55);
    push(8'h0A, 8'h55);
    push(8'h0A, 8'h55);
    wait_for("cfg_err_set", 2, 1'b1, 500, t);
    check("three_issues", hs_idx, exp_n);
    check("err_txdis", tx_disable, 1'b1);
    ticks(10);
    check("err_sticky", cfg_err, 1'b1);
    check("err_no_reissue", hs_idx, exp_n);
    push(8'h0A, 8'h55);
    push(8'h1B, 8'hAA);
    reconf = 1'b1;
    tick();
    reconf = 1'b0;
    check("reconf_clears_err", cfg_err, 1'b0);
    wait_for("reconf_run", 0, 1'b0, 500, t);
    check("reconf_writes", hs_idx, exp_n);
    bus.cmd_ready = 1'b0;
    rom[0] = 16'h3C5A;
    rom[1] = 16'hFFFF;
    do_reset();
    push(8'h3C, 8'h5A);
    wait_for("stall_valid", 1, 1'b1, 100, t);
    check("stall_fields", fields(), {7'h68, 8'h3C, 8'h5A});
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid_held", bus.cmd_valid, 1'b1);
    end
    bus.cmd_ready = 1'b1;
    wait_for("stall_run", 0, 1'b0, 300, t);
    check("stall_single_write", hs_idx, exp_n);
    bus.cmd_ready = 1'b0;
    do_reset();
    wait_for("midrst_valid", 1, 1'b1, 100, t);
    do_reset();
    push(8'h3C, 8'h5A);
    wait_for("midrst_restart", 1, 1'b1, 100, t);
    check("midrst_latency", t, SW + 2);
    bus.cmd_ready = 1'b1;
    wait_for("midrst_run", 0, 1'b0, 300, t);
    check("midrst_writes", hs_idx, exp_n);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sfp_link_ctrl.md
SFP_LINK_CTRL -- requirements
Module: sfp_link_ctrl

Interface
REQ-001 SHALL have parameter STARTUP_WAIT, default 16'd10000, meaning cycles held after reset before the first configuration write.
REQ-002 SHALL have parameter LOCK_TIME, default 16'd1000, meaning consecutive alarm-free cycles required to declare the clock locked.
REQ-003 SHALL have parameter RETRY_WAIT, default 16'd5000, meaning cycles held with TX disabled after a TX fault.
REQ-004 SHALL have parameter MAX_RETRY, default 2'd3, meaning I2C retries per table entry before a permanent error.
REQ-005 SHALL have parameter DEV_ADDR, default 7'h68, meaning the I2C address of the clock synthesizer.
REQ-006 SHALL have clk100  input  1  meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have sys_rst_n  input  1  meaning the reset, which is asynchronous and active-low.
REQ-008 SHALL have cfg_addr  output  6  meaning the configuration-table index.
REQ-009 SHALL have cfg_data  input  16  meaning the table entry {reg[15:8], data[7:0]}, valid one cycle after cfg_addr; 16'hFFFF marks end of table.
REQ-010 SHALL have cmd_valid/cmd_ready  output/input  1/1  meaning the write-command handshake to the I2C master.
REQ-011 SHALL have cmd_dev, cmd_reg, cmd_data  output  7/8/8  meaning the write command fields.
REQ-012 SHALL have cmd_done/cmd_err  input  1/1  meaning a one-cycle completion pulse, with cmd_err qualifying a failure.
REQ-013 SHALL have clk_alarm_b, tx_fault, rx_los, reconf  input  1 each  meaning the asynchronous SFP/clock status lines and a reconfigure pulse.
REQ-014 SHALL have tx_disable, link_up, cfg_err  output  1 each  meaning the SFP transmit disable, the link status, and a sticky configuration failure flag.
REQ-015 SHALL have fault_cnt  output  8  meaning the number of TX faults, saturating.

Function
REQ-016 SHALL synchronize clk_alarm_b, tx_fault and rx_los through 2 flops each; all references below use the synchronized values.
REQ-017 SHALL implement the states STARTUP, FETCH, ISSUE, WAIT, LOCK, RUN, FAULT_HOLD and ERROR.
REQ-018 STARTUP SHALL count STARTUP_WAIT cycles and then enter FETCH with cfg_addr=0.
REQ-019 FETCH SHALL wait one cycle for cfg_data, go to LOCK if the entry is 16'hFFFF, and otherwise go to ISSUE.
REQ-020 ISSUE SHALL assert cmd_valid with cmd_dev=DEV_ADDR, cmd_reg=cfg_data[15:8] and cmd_data=cfg_data[7:0], holding the fields stable until cmd_ready; on that handshake cycle it SHALL deassert cmd_valid and enter WAIT.
REQ-021 On cmd_done with !cmd_err, WAIT SHALL increment cfg_addr; it SHALL then go to LOCK if the index wraps from 63 to 0, and to FETCH otherwise.
REQ-022 On cmd_done with cmd_err, WAIT SHALL increment the retry counter and return to ISSUE for the same entry; after the MAX_RETRY-th consecutive error it SHALL enter ERROR with cfg_err=1.
REQ-023 The retry counter SHALL clear on each successful entry.
REQ-024 cmd_done and cmd_err SHALL be ignored outside WAIT.
REQ-025 LOCK SHALL count cycles while clk_alarm_b=1, clear the counter whenever clk_alarm_b=0, and enter RUN when the count reaches LOCK_TIME.
REQ-026 tx_disable SHALL be 0 only in RUN.
REQ-027 In RUN, link_up SHALL equal !rx_los && !tx_fault, registered; link_up SHALL be 0 in every other state.
REQ-028 In RUN, tx_fault=1 SHALL enter FAULT_HOLD and increment fault_cnt, saturating at 255.
REQ-029 FAULT_HOLD SHALL count RETRY_WAIT cycles and then enter LOCK.
REQ-030 In RUN, clk_alarm_b=0 with tx_fault=0 SHALL enter LOCK; if both occur together, the tx_fault path has priority.
REQ-031 rx_los SHALL affect only link_up and SHALL never cause a state change.
REQ-032 A reconf pulse in RUN or ERROR SHALL clear cfg_err and the retry counter, set cfg_addr=0 and enter FETCH; reconf SHALL be ignored in all other states.
REQ-033 ERROR SHALL hold tx_disable=1 and leave only on reconf or reset.

Reset
REQ-034 While sys_rst_n=0, the block SHALL hold state STARTUP, all counters 0, cfg_addr=0, cmd_valid=0, cmd_dev/reg/data=0, tx_disable=1, link_up=0, cfg_err=0, fault_cnt=0 and the synchronizers at 0.
REQ-035 Reset assertion mid-operation, including with cmd_valid high, SHALL drop cmd_valid immediately and restart from STARTUP on release.

Verification
REQ-036 Table {0x0A55, 0x1BAA, 0xFFFF}, cmd_ready=1, cmd_done ok, alarm_b=1 -> exactly 2 writes (0x68/0x0A/0x55, 0x68/0x1B/0xAA), then tx_disable=0 exactly LOCK_TIME cycles after the second done (+sync).
REQ-037 cmd_ready held low 20 cycles -> cmd_valid and fields stable throughout; a single write is issued.
REQ-038 Entry 0 returns cmd_err on 3 consecutive attempts -> 3 issues of the same entry, then cfg_err=1, tx_disable=1; a following reconf -> cfg_err=0 and re-issue from entry 0.
REQ-039 alarm_b toggles low every 500 cycles during LOCK -> never reaches RUN; alarm_b steady -> RUN.
REQ-040 In RUN, tx_fault pulses and alarm_b drops on the same cycle -> FAULT_HOLD, fault_cnt=1, tx_disable=1 for RETRY_WAIT cycles, then LOCK; 300 faults -> fault_cnt=255.
REQ-041 In RUN, rx_los=1 -> link_up=0, tx_disable stays 0, no state change.
